// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;
    localparam int MAX_N  = 8;

    // Round-robin pick: first set bit of valid scanning from ptr+1 upward,
    // wrapping modulo n. Returns 0 when nothing is valid.
    function automatic int rr_pick(input logic [MAX_N-1:0] valid,
                                   input int ptr,
                                   input int n = MAX_N);
        int cand;
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int k = 1; k <= MAX_N; k++) begin
            cand = ptr + k;
            if (cand >= n) cand = cand - n;
            if (k <= n && !found && valid[cand[2:0]]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write pins of the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_last;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic               fifo_wr_en;
    logic [WIDTH-1:0]   fifo_din;
    logic               fifo_full;
    logic [N-1:0]       grant;
    logic               busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant, busy
    );

    // Requesters / FIFO side
    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority.sv
// N-bit rotate-priority encoder: first valid index after ptr, modulo N.
module rr_priority import fifo_arb_pkg::*; #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [MAX_N-1:0] valid_ext;

    // Widen to the helper's fixed width and pick the winner
    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
        idx              = IW'(rr_pick(valid_ext, int'(ptr), N));
        any              = |valid;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a FIFO write port.
// A requester keeps the grant until its last beat or MAX_BURST beats.
// Optional: define FIFO_ARB_STATS_EN for per-requester burst counters.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FIFO_ARB_STATS_EN
    input  logic               stat_clr,
    output logic [N*STAT_W-1:0] stat_bursts,
`endif
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            last_or_cap;
    logic [N-1:0]    ready_c;
    logic [N-1:0]    grant_c;
    logic            wr_en_c;
    logic [WIDTH-1:0] din_c;

    rr_priority #(.N(N)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Next-state and owner-muxed write path
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        ready_c     = '0;
        wr_en_c     = 1'b0;
        din_c       = '0;
        last_or_cap = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    owner_d    = win_idx;
                    rr_ptr_d   = win_idx;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                for (int i = 0; i < N; i++) begin
                    if (owner_q == IW'(i)) begin
                        ready_c[i]  = !bus.fifo_full;
                        din_c       = bus.req_data[i*WIDTH +: WIDTH];
                        wr_en_c     = bus.req_valid[i] & !bus.fifo_full;
                        last_or_cap = bus.req_last[i] || (beat_cnt_q + 1'b1 == CAP);
                    end
                end
                if (wr_en_c) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_or_cap) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle aborts the burst: nothing may land in the FIFO
        if (rst) begin
            ready_c = '0;
            wr_en_c = 1'b0;
        end
    end

    // Registered one-hot grant view of the owner
    always_comb begin
        for (int i = 0; i < N; i++)
            grant_c[i] = (state_q == LOCK) && (owner_q == IW'(i));
    end

    assign bus.req_ready  = ready_c;
    assign bus.fifo_wr_en = wr_en_c;
    assign bus.fifo_din   = din_c;
    assign bus.grant      = grant_c;
    assign bus.busy       = (state_q == LOCK);

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IW'(N - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic                      rel_fire;
    logic [N-1:0][STAT_W-1:0]  stat_q, stat_d;

    assign rel_fire = (state_q == LOCK) && wr_en_c && last_or_cap;

    // Saturating per-requester release counters; clear wins over increment
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < N; i++) begin
            if (rel_fire && owner_q == IW'(i) && stat_q[i] != '1)
                stat_d[i] = stat_q[i] + 1'b1;
        end
        if (stat_clr) stat_d = '0;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_bursts = stat_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a queue-based reference model.
// Covers the FIFO_ARB_STATS_EN counters when that macro is defined.
module tb_fifo_wr_arbiter;
    localparam int N = 4, W = 8, MB = 16, DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .WIDTH(W)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [N*16-1:0] stat_bursts;
    int              m_stat [N];
`endif

    fifo_wr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FIFO_ARB_STATS_EN
        .stat_clr    (stat_clr),
        .stat_bursts (stat_bursts),
`endif
        .bus         (bus)
    );

    // Requester streams, FIFO contents and the log of accepted beats
    logic [7:0] src_d [N][$];
    bit         src_l [N][$];
    logic [7:0] fifo_q [$];
    int         log_own [$];
    logic [7:0] log_dat [$];
    int         log_cyc [$];

    // Reference model: owner (-1 = idle), last owner, beats in this burst
    int m_owner = -1, m_ptr = N - 1, m_beats = 0, cyc = 0;
    int gate_pct = 100, pop_pct = 100;
    bit force_pop = 1'b0, rst_in = 1'b0, cur_full;

    logic [N-1:0] obs_grant, obs_ready;
    logic         obs_busy, obs_wr;
    logic [W-1:0] obs_din;
    // Layout: {grant[3:0], busy, wr_en, ready[3:0], din[7:0]}
    logic [17:0]  obs_vec, exp_vec;

    int n_chk = 0, n_pass = 0;

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_d[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit drained();
        return all_empty() && m_owner < 0;
    endfunction

    // mode: 0 never last, k>0 last every k-th byte, -1 random last (final forced)
    task automatic load(input int r, input int cnt, input int base, input int mode);
        for (int k = 0; k < cnt; k++) begin
            src_d[r].push_back(base < 0 ? 8'($urandom) : 8'(base + k));
            if (mode > 0)       src_l[r].push_back((k % mode) == mode - 1);
            else if (mode < 0)  src_l[r].push_back(k == cnt - 1 || $urandom_range(3) == 0);
            else                src_l[r].push_back(1'b0);
        end
    endtask

    // One cycle: drive at negedge, sample, advance model, cross the edge
    task automatic tick();
        logic [N-1:0]   v, l, eg, er;
        logic [N*W-1:0] d;
        logic [W-1:0]   ed;
        logic           ew, care;
        int             win, o, had;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (src_d[i].size() > 0) begin
                d[i*W +: W] = src_d[i][0];
                l[i]        = src_l[i][0];
                v[i]        = int'($urandom_range(99)) < gate_pct;
            end
        end
        cur_full = fifo_q.size() >= DEPTH;
        bus.req_valid = v; bus.req_last = l; bus.req_data = d;
        bus.fifo_full = cur_full;
        rst = rst_in;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        #1;
        obs_grant = bus.grant; obs_busy = bus.busy; obs_wr = bus.fifo_wr_en;
        obs_ready = bus.req_ready; obs_din = bus.fifo_din;

        eg = '0; er = '0; ew = 1'b0; ed = '0; care = 1'b0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        had = fifo_q.size();
        if (rst_in) begin
            m_owner = -1; m_ptr = N - 1; m_beats = 0;
`ifdef FIFO_ARB_STATS_EN
            for (int i = 0; i < N; i++) m_stat[i] = 0;
`endif
        end else if (m_owner < 0) begin
            care = 1'b1;
            if (v != '0) begin
                win = 0;
                for (int k = 1; k <= N; k++)
                    if (v[(m_ptr + k) % N]) begin win = (m_ptr + k) % N; break; end
                m_owner = win; m_ptr = win; m_beats = 0;
            end
        end else begin
            o = m_owner;
            if (!cur_full) er[o] = 1'b1;
            ew   = v[o] && !cur_full;
            ed   = d[o*W +: W];
            care = ew;
            if (ew) begin
                fifo_q.push_back(ed);
                log_own.push_back(o); log_dat.push_back(ed); log_cyc.push_back(cyc);
                void'(src_d[o].pop_front()); void'(src_l[o].pop_front());
                m_beats++;
                if (l[o] || m_beats == MB) begin
                    m_owner = -1;
`ifdef FIFO_ARB_STATS_EN
                    if (m_stat[o] < 65535) m_stat[o]++;
`endif
                end
            end
        end
        if (!rst_in && had > 0 && (force_pop || int'($urandom_range(99)) < pop_pct))
            void'(fifo_q.pop_front());
        force_pop = 1'b0;
        exp_vec = {eg, m_owner_busy(eg), ew, er, care ? ed : 8'h00};
        obs_vec = {obs_grant, obs_busy, obs_wr, obs_ready, care ? obs_din : 8'h00};
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic m_owner_busy(input logic [N-1:0] g);
        return |g;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin src_d[i].delete(); src_l[i].delete(); end
        fifo_q.delete();
        rst_in = 1'b1; tick(); tick(); rst_in = 1'b0;
        log_own.delete(); log_dat.delete(); log_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_chk++;
        if (obs_grant !== '0 || obs_busy !== 1'b0 || obs_ready !== '0 || obs_wr !== 1'b0)
            $display("FAIL reset_state got grant=%b busy=%b ready=%b wr=%b want all 0",
                     obs_grant, obs_busy, obs_ready, obs_wr);
        else n_pass++;
        n_chk++;
        if (obs_vec !== exp_vec) $display("FAIL reset_cycle got %h want %h", obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_rr_priority();
        int want [5] = '{0, 1, 2, 3, 0};
        bit ok_o, ok_gap;
        do_reset();
        load(0, 2, -1, 1);
        for (int r = 1; r < N; r++) load(r, 1, -1, 1);
        for (int c = 0; c < 60 && !drained(); c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL rr_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        ok_o = log_own.size() == 5;
        ok_gap = ok_o;
        for (int k = 0; k < log_own.size() && k < 5; k++) if (log_own[k] != want[k]) ok_o = 1'b0;
        for (int k = 1; k < log_cyc.size(); k++) if (log_cyc[k] - log_cyc[k-1] != 2) ok_gap = 1'b0;
        n_chk++;
        if (!ok_o) $display("FAIL rr_order got %0d beats, owners %p want 0,1,2,3,0", log_own.size(), log_own);
        else n_pass++;
        n_chk++;
        if (!ok_gap) $display("FAIL rr_bubble beat cycles %p want spacing 2", log_cyc);
        else n_pass++;
    endtask

    task automatic test_burst_integrity();
        bit ok;
        log_own.delete(); log_dat.delete(); log_cyc.delete();
        load(1, 4, 'h10, 4);
        load(2, 6, -1, 3);
        for (int c = 0; c < 60 && !drained(); c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL integ_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        ok = log_own.size() == 10;
        for (int k = 0; k < log_own.size() && ok; k++) begin
            if (k < 4 && (log_own[k] != 1 || log_dat[k] != 8'(16 + k))) ok = 1'b0;
            if (k >= 4 && log_own[k] != 2) ok = 1'b0;
        end
        n_chk++;
        if (!ok) $display("FAIL burst_integrity owners %p data %p want req1 10..13 then req2", log_own, log_dat);
        else n_pass++;
    endtask

    task automatic test_burst_cap();
        bit ok;
        int wo;
        do_reset();
        load(0, 40, -1, 0);
        load(3, 8, -1, 8);
        for (int c = 0; c < 200 && !all_empty(); c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL cap_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        ok = log_own.size() == 48;
        for (int k = 0; k < log_own.size() && ok; k++) begin
            wo = (k >= 16 && k < 24) ? 3 : 0;
            if (log_own[k] != wo) ok = 1'b0;
        end
        n_chk++;
        if (!ok) $display("FAIL burst_cap got %0d beats owners %p want 16x0 8x3 24x0", log_own.size(), log_own);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nw;
        do_reset();
        pop_pct = 0;
        load(1, 40, -1, 8);
        for (int c = 0; c < 100 && fifo_q.size() < DEPTH; c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL bp_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        n_chk++;
        if (fifo_q.size() != DEPTH) $display("FAIL bp_fill got %0d entries want %0d", fifo_q.size(), DEPTH);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (obs_wr !== 1'b0 || obs_ready !== '0)
                $display("FAIL bp_full_stall got wr=%b ready=%b want 0/0 while full", obs_wr, obs_ready);
            else n_pass++;
        end
        force_pop = 1'b1;
        tick();
        nw = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (obs_wr === 1'b1) nw++;
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL bp_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        n_chk++;
        if (nw != 1) $display("FAIL bp_one_beat got %0d beats after one read want 1", nw);
        else n_pass++;
        pop_pct = 100;
    endtask

    task automatic test_mid_reset();
        do_reset();
        load(1, 10, -1, 10);
        for (int c = 0; c < 20 && !(m_owner == 1 && m_beats == 2); c++) tick();
        n_chk++;
        if (!(m_owner == 1 && m_beats == 2)) $display("FAIL mreset_setup owner=%0d beats=%0d want 1/2", m_owner, m_beats);
        else n_pass++;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_chk++;
        if (obs_wr !== 1'b0) $display("FAIL mreset_no_write got wr=%b want 0", obs_wr);
        else n_pass++;
        load(0, 3, -1, 3);
        load(2, 3, -1, 3);
        tick();
        n_chk++;
        if (obs_grant !== '0 || obs_busy !== 1'b0 || obs_wr !== 1'b0)
            $display("FAIL mreset_after got grant=%b busy=%b wr=%b want 0/0/0", obs_grant, obs_busy, obs_wr);
        else n_pass++;
        tick();
        n_chk++;
        if (obs_grant !== 4'b0001) $display("FAIL mreset_first got grant=%b want 0001", obs_grant);
        else n_pass++;
        for (int c = 0; c < 80 && !drained(); c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL mreset_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        gate_pct = 70; pop_pct = 60;
        for (int r = 0; r < N; r++) load(r, 25, -1, -1);
        for (int c = 0; c < 2000 && !drained(); c++) begin
            tick();
            n_chk++;
            if (obs_vec !== exp_vec) $display("FAIL rand_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        n_chk++;
        if (!drained() || log_own.size() != 4 * 25)
            $display("FAIL rand_drain got %0d beats want %0d", log_own.size(), 4 * 25);
        else n_pass++;
        gate_pct = 100; pop_pct = 100;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        load(2, 15, -1, 3);
        for (int c = 0; c < 100 && !drained(); c++) tick();
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (stat_bursts[i*16 +: 16] !== 16'(m_stat[i]) || stat_bursts[i*16 +: 16] !== (i == 2 ? 16'd5 : 16'd0))
                $display("FAIL stats_count[%0d] got %0d want %0d", i, stat_bursts[i*16 +: 16], m_stat[i]);
            else n_pass++;
        end
        stat_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stat_clr = 1'b0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
        n_chk++;
        if (stat_bursts !== '0) $display("FAIL stats_clear got %h want 0", stat_bursts);
        else n_pass++;
    endtask
`endif

    initial begin
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_priority();
        test_burst_integrity();
        test_burst_cap();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
